// File: rtl/logic_accum_unit_if.sv
// logic_accum_unit_if
//   Bundles the beat input handshake and the result output handshake of
//   logic_accum_unit.
//   master : the environment. It drives beats and consumes results.
//   slave  : the unit itself.
//   Signals:
//     IN_VALID/IN_READY      beat handshake
//     I1, I2, OP, ACC, LAST  beat payload
//     OUT_VALID/OUT_READY    result handshake
//     O, PAR, BEATS, OVF     result payload
interface logic_accum_unit_if #(
  parameter int WIDTH     = 8,
  parameter int MAX_BEATS = 16
);
  localparam int CW = $clog2(MAX_BEATS + 1);

  logic             IN_VALID;
  logic             IN_READY;
  logic [WIDTH-1:0] I1;
  logic [WIDTH-1:0] I2;
  logic [1:0]       OP;
  logic             ACC;
  logic             LAST;
  logic             OUT_VALID;
  logic             OUT_READY;
  logic [WIDTH-1:0] O;
  logic             PAR;
  logic [CW-1:0]    BEATS;
  logic             OVF;

  modport master (
    output IN_VALID, I1, I2, OP, ACC, LAST, OUT_READY,
    input  IN_READY, OUT_VALID, O, PAR, BEATS, OVF
  );

  modport slave (
    input  IN_VALID, I1, I2, OP, ACC, LAST, OUT_READY,
    output IN_READY, OUT_VALID, O, PAR, BEATS, OVF
  );
endinterface

// File: rtl/logic_accum_unit.sv
// logic_accum_unit
//   Registered two-operand bitwise logic unit (AND/OR/XOR/XNOR). It can also
//   fold a burst of operand pairs into one result. A burst ends on LAST, or
//   it is forced to end after MAX_BEATS beats, and that forced end is flagged
//   on OVF.
//   Ports:
//     CLK  clock, rising edge
//     RST  asynchronous active-high reset
//     bus  logic_accum_unit_if.slave. It carries the beat handshake, the
//          operands, OP/ACC/LAST, the result handshake and O/PAR/BEATS/OVF.
module logic_accum_unit #(
  parameter int WIDTH     = 8,
  parameter int MAX_BEATS = 16
) (
  input logic                 CLK,
  input logic                 RST,
  logic_accum_unit_if.slave   bus
);
  localparam int CW = $clog2(MAX_BEATS + 1);

  typedef enum logic {IDLE, ACCUM} state_t;

  function automatic logic [WIDTH-1:0] apply_op(input logic [1:0]       op,
                                                input logic [WIDTH-1:0] a,
                                                input logic [WIDTH-1:0] b);
    logic [WIDTH-1:0] res;
    case (op)
      2'b00:   res = a & b;
      2'b01:   res = a | b;
      2'b10:   res = a ^ b;
      default: res = ~(a ^ b);
    endcase
    return res;
  endfunction

  state_t           state;
  logic [WIDTH-1:0] acc;
  logic [1:0]       op_lat;
  logic [CW-1:0]    cnt;

  logic [WIDTH-1:0] o_p1;
  logic             par_p1;
  logic [CW-1:0]    beats_p1;
  logic             ovf_p1;
  logic             vld_p1;

  logic             in_fire;
  logic             out_fire;
  logic [1:0]       beat_op;
  logic [WIDTH-1:0] r;
  logic [WIDTH-1:0] n;
  logic [CW-1:0]    cnt_nx;

  assign bus.IN_READY = !vld_p1 || bus.OUT_READY;
  assign in_fire      = bus.IN_VALID && bus.IN_READY;
  assign out_fire     = vld_p1 && bus.OUT_READY;

  // Inside a burst the operator latched on the first beat applies both to the
  // pair and to the fold, so a changing OP input cannot alter the burst.
  assign beat_op = (state == ACCUM) ? op_lat : bus.OP;
  assign r       = apply_op(beat_op, bus.I1, bus.I2);
  assign n       = apply_op(op_lat, acc, r);
  assign cnt_nx  = cnt + CW'(1);

  // ---- stage p1: result register and burst state ----
  always_ff @(posedge CLK or posedge RST) begin
    if (RST) begin
      state    <= IDLE;
      acc      <= '0;
      op_lat   <= 2'b00;
      cnt      <= '0;
      o_p1     <= '0;
      par_p1   <= 1'b0;
      beats_p1 <= '0;
      ovf_p1   <= 1'b0;
      vld_p1   <= 1'b0;
    end else begin
      // When a load happens in the same cycle as a drain, the load assignment
      // below takes precedence, so OUT_VALID stays high back-to-back.
      if (out_fire) begin
        vld_p1 <= 1'b0;
      end
      if (in_fire) begin
        case (state)
          IDLE: begin
            if (!bus.ACC || bus.LAST) begin
              o_p1     <= r;
              par_p1   <= ^r;
              beats_p1 <= CW'(1);
              ovf_p1   <= 1'b0;
              vld_p1   <= 1'b1;
            end else begin
              acc    <= r;
              op_lat <= bus.OP;
              cnt    <= CW'(1);
              state  <= ACCUM;
            end
          end
          default: begin
            acc <= n;
            cnt <= cnt_nx;
            if (bus.LAST || (cnt_nx == CW'(MAX_BEATS))) begin
              o_p1     <= n;
              par_p1   <= ^n;
              beats_p1 <= cnt_nx;
              ovf_p1   <= !bus.LAST;
              vld_p1   <= 1'b1;
              state    <= IDLE;
            end
          end
        endcase
      end
    end
  end

  assign bus.O         = o_p1;
  assign bus.PAR       = par_p1;
  assign bus.BEATS     = beats_p1;
  assign bus.OVF       = ovf_p1;
  assign bus.OUT_VALID = vld_p1;
endmodule

// File: tb/tb_logic_accum_unit.sv
// tb_logic_accum_unit
//   Bench for logic_accum_unit with WIDTH=8 and MAX_BEATS=4. A burst-level
//   reference model collects the beats of each burst and folds them when the
//   burst terminates. A negedge process compares every output against that
//   model on every cycle. Directed scenarios add literal expectations.
module tb_logic_accum_unit;
  localparam int WIDTH     = 8;
  localparam int MAX_BEATS = 4;
  localparam int CW        = $clog2(MAX_BEATS + 1);

  logic CLK = 1'b0;
  logic RST;

  logic_accum_unit_if #(.WIDTH(WIDTH), .MAX_BEATS(MAX_BEATS)) bus ();

  logic_accum_unit #(.WIDTH(WIDTH), .MAX_BEATS(MAX_BEATS)) dut (
    .CLK (CLK),
    .RST (RST),
    .bus (bus)
  );

  always #5 CLK = ~CLK;

  int n_chk  = 0;
  int n_pass = 0;

  task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
    n_chk++;
    if (act === exp) n_pass++;
    else $display("FAIL %s: got %0h, want %0h", name, act, exp);
  endtask

  // ---------------- reference model ----------------
  function automatic logic [WIDTH-1:0] gate(input logic [1:0] op,
                                            input logic [WIDTH-1:0] a,
                                            input logic [WIDTH-1:0] b);
    case (op)
      2'b00:   return a & b;
      2'b01:   return a | b;
      2'b10:   return a ^ b;
      default: return ~(a ^ b);
    endcase
  endfunction

  logic [WIDTH-1:0] m_o     = '0;
  logic             m_par   = 1'b0;
  logic [CW-1:0]    m_beats = '0;
  logic             m_ovf   = 1'b0;
  logic             m_valid = 1'b0;
  bit               in_burst = 1'b0;
  logic [1:0]       burst_op = 2'b00;
  logic [WIDTH-1:0] beats_q[$];

  task automatic produce(input logic [WIDTH-1:0] v, input int cnt, input logic ovf);
    m_o     = v;
    m_par   = ^v;
    m_beats = CW'(cnt);
    m_ovf   = ovf;
    m_valid = 1'b1;
  endtask

  always @(posedge CLK or posedge RST) begin
    logic             fire;
    logic [WIDTH-1:0] folded;
    if (RST) begin
      m_o = '0; m_par = 1'b0; m_beats = '0; m_ovf = 1'b0; m_valid = 1'b0;
      in_burst = 1'b0; burst_op = 2'b00; beats_q.delete();
    end else begin
      fire = bus.IN_VALID && (!m_valid || bus.OUT_READY);
      if (m_valid && bus.OUT_READY) m_valid = 1'b0;
      if (fire) begin
        if (!in_burst) begin
          if (!bus.ACC || bus.LAST) begin
            produce(gate(bus.OP, bus.I1, bus.I2), 1, 1'b0);
          end else begin
            in_burst = 1'b1;
            burst_op = bus.OP;
            beats_q.delete();
            beats_q.push_back(gate(bus.OP, bus.I1, bus.I2));
          end
        end else begin
          beats_q.push_back(gate(burst_op, bus.I1, bus.I2));
          if (bus.LAST || beats_q.size() == MAX_BEATS) begin
            folded = beats_q[0];
            for (int i = 1; i < beats_q.size(); i++) folded = gate(burst_op, folded, beats_q[i]);
            produce(folded, beats_q.size(), !bus.LAST);
            in_burst = 1'b0;
            beats_q.delete();
          end
        end
      end
    end
  end

  // ---------------- per-cycle compare ----------------
  always @(negedge CLK) begin
    chk("in_ready",  32'(bus.IN_READY),  32'(!m_valid || bus.OUT_READY));
    chk("out_valid", 32'(bus.OUT_VALID), 32'(m_valid));
    chk("o",         32'(bus.O),         32'(m_o));
    chk("par",       32'(bus.PAR),       32'(m_par));
    chk("beats",     32'(bus.BEATS),     32'(m_beats));
    chk("ovf",       32'(bus.OVF),       32'(m_ovf));
  end

  // ---------------- stimulus ----------------
  task automatic idle(input int n);
    bus.IN_VALID = 1'b0;
    repeat (n) begin @(posedge CLK); #1; end
  endtask

  task automatic send(input logic [7:0] i1, input logic [7:0] i2, input logic [1:0] op,
                      input logic acc, input logic last);
    logic rdy;
    bit   done;
    bus.IN_VALID = 1'b1; bus.I1 = i1; bus.I2 = i2; bus.OP = op; bus.ACC = acc; bus.LAST = last;
    done = 1'b0;
    for (int k = 0; k < 20 && !done; k++) begin
      @(negedge CLK); rdy = bus.IN_READY;
      @(posedge CLK); #1;
      if (rdy) done = 1'b1;
    end
    if (!done) chk("send_timeout", 32'd0, 32'd1);
    bus.IN_VALID = 1'b0;
  endtask

  task automatic expect_res(input string name, input logic [7:0] o, input logic par,
                            input int beats, input logic ovf);
    chk({name, "_o"},     32'(bus.O),         32'(o));
    chk({name, "_par"},   32'(bus.PAR),       32'(par));
    chk({name, "_beats"}, 32'(bus.BEATS),     32'(beats));
    chk({name, "_ovf"},   32'(bus.OVF),       32'(ovf));
    chk({name, "_vld"},   32'(bus.OUT_VALID), 32'd1);
  endtask

  initial begin
    RST = 1'b1;
    bus.IN_VALID = 1'b0; bus.I1 = '0; bus.I2 = '0; bus.OP = 2'b00;
    bus.ACC = 1'b0; bus.LAST = 1'b0; bus.OUT_READY = 1'b1;
    #1;
    bus.IN_VALID = 1'b1; bus.I1 = 8'hFF; bus.I2 = 8'hFF;
    repeat (2) begin @(posedge CLK); #1; end
    chk("rst_vld",   32'(bus.OUT_VALID), 32'd0);
    chk("rst_o",     32'(bus.O),         32'd0);
    chk("rst_beats", 32'(bus.BEATS),     32'd0);
    chk("rst_rdy",   32'(bus.IN_READY),  32'd1);
    bus.IN_VALID = 1'b0;
    RST = 1'b0;
    idle(2);

    // single XOR
    send(8'hA5, 8'h0F, 2'b10, 1'b0, 1'b0);
    expect_res("xor1", 8'hAA, 1'b0, 1, 1'b0);
    idle(2);

    // XOR burst of three
    send(8'h01, 8'h00, 2'b10, 1'b1, 1'b0);
    chk("burst_vld1", 32'(bus.OUT_VALID), 32'd0);
    send(8'h02, 8'h00, 2'b10, 1'b0, 1'b0);
    chk("burst_vld2", 32'(bus.OUT_VALID), 32'd0);
    send(8'h04, 8'h00, 2'b10, 1'b0, 1'b1);
    expect_res("burst", 8'h07, 1'b1, 3, 1'b0);
    idle(2);

    // AND burst forced to end at MAX_BEATS, then a fresh single beat
    send(8'hFF, 8'hF0, 2'b00, 1'b1, 1'b0);
    send(8'h3C, 8'hFF, 2'b00, 1'b0, 1'b0);
    send(8'hFF, 8'hFF, 2'b00, 1'b0, 1'b0);
    send(8'hF0, 8'hFF, 2'b00, 1'b0, 1'b0);
    expect_res("ovf", 8'h30, 1'b0, 4, 1'b1);
    send(8'h0F, 8'hF0, 2'b01, 1'b0, 1'b0);
    expect_res("after_ovf", 8'hFF, 1'b0, 1, 1'b0);
    idle(2);

    // LAST on the MAX_BEATS beat is a normal end
    send(8'h01, 8'h00, 2'b01, 1'b1, 1'b0);
    send(8'h02, 8'h00, 2'b01, 1'b0, 1'b0);
    send(8'h04, 8'h00, 2'b01, 1'b0, 1'b0);
    send(8'h08, 8'h00, 2'b01, 1'b0, 1'b1);
    expect_res("last_at_max", 8'h0F, 1'b0, 4, 1'b0);
    idle(2);

    // OP change mid-burst is ignored
    send(8'hFF, 8'h0F, 2'b00, 1'b1, 1'b0);
    send(8'h3C, 8'hFF, 2'b01, 1'b0, 1'b1);
    expect_res("op_chg", 8'h0C, 1'b0, 2, 1'b0);
    idle(2);

    // backpressure, then a simultaneous drain and load
    bus.OUT_READY = 1'b0;
    send(8'hA5, 8'h0F, 2'b10, 1'b0, 1'b0);
    bus.IN_VALID = 1'b1; bus.I1 = 8'h33; bus.I2 = 8'h0F; bus.OP = 2'b00;
    bus.ACC = 1'b0; bus.LAST = 1'b0;
    for (int k = 0; k < 3; k++) begin
      @(posedge CLK); #1;
      chk("bp_hold_o", 32'(bus.O),        32'h0000_00AA);
      chk("bp_rdy",    32'(bus.IN_READY), 32'd0);
    end
    bus.OUT_READY = 1'b1;
    @(posedge CLK); #1;
    bus.IN_VALID = 1'b0;
    expect_res("bp_b2b", 8'h03, 1'b0, 1, 1'b0);
    idle(2);

    // reset mid-burst
    send(8'h01, 8'h00, 2'b01, 1'b1, 1'b0);
    send(8'h02, 8'h00, 2'b01, 1'b0, 1'b0);
    RST = 1'b1;
    #1;
    chk("mrst_o",   32'(bus.O),         32'd0);
    chk("mrst_vld", 32'(bus.OUT_VALID), 32'd0);
    @(posedge CLK); #1;
    RST = 1'b0;
    send(8'h10, 8'h00, 2'b01, 1'b1, 1'b0);
    send(8'h20, 8'h00, 2'b01, 1'b0, 1'b1);
    expect_res("post_rst", 8'h30, 1'b0, 2, 1'b0);
    idle(3);

    $display("%0d/%0d checks passed", n_pass, n_chk);
    $finish;
  end

  initial begin
    #200000;
    $display("FAIL watchdog: got timeout, want finish");
    $fatal(1, "watchdog");
  end
endmodule
